// File: rtl/adpll_lock_detect_if.sv
// Status/control bundle between the lock detector and its surroundings.
// The reference and feedback clocks arrive asynchronously; the filter and
// configuration fields are synchronous to the detector's system clock.
interface adpll_lock_detect_if;
  logic       clk_ref;
  logic       fb_clk;
  logic       filter_sign;
  logic [4:0] filter_out;
  logic [4:0] err_thresh;
  logic [3:0] lock_count;
  logic       locked;
  logic       lost_lock;
  logic       ref_timeout;
  logic [1:0] lock_state;

  // Driver side: supplies clocks, filter value and configuration.
  modport master (
    output clk_ref, fb_clk, filter_sign, filter_out, err_thresh, lock_count,
    input  locked, lost_lock, ref_timeout, lock_state
  );

  // Detector side.
  modport slave (
    input  clk_ref, fb_clk, filter_sign, filter_out, err_thresh, lock_count,
    output locked, lost_lock, ref_timeout, lock_state
  );
endinterface

// File: rtl/adpll_lock_detect.sv
// ADPLL lock detector: frequency lock from feedback edges counted over a
// window of reference edges, phase lock from the loop-filter magnitude, plus
// a reference-loss timeout. All outputs are registered.
module adpll_lock_detect #(
  parameter int unsigned WIN_LOG2 = 4,
  parameter int unsigned FREQ_TOL = 1,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned TO_LOG2  = 10
) (
  input logic             clk,
  input logic             rst_n,
  input logic             clr,
  adpll_lock_detect_if.slave bus
);

  localparam int unsigned FbW   = WIN_LOG2 + 2;
  localparam int unsigned MissW = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  localparam logic [FbW-1:0]   WinLen  = FbW'(1) << WIN_LOG2;
  localparam logic [FbW-1:0]   FreqTol = FbW'(FREQ_TOL);
  localparam logic [MissW-1:0] MissMax = MissW'(MISS_MAX);

  typedef enum logic [1:0] {
    StUnlocked  = 2'd0,
    StAcquiring = 2'd1,
    StLocked    = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          ref_sync_q, ref_sync_d;
  logic [2:0]          fb_sync_q, fb_sync_d;
  logic [WIN_LOG2-1:0] ref_cnt_q, ref_cnt_d;
  logic [FbW-1:0]      fb_cnt_q, fb_cnt_d;
  logic [3:0]          acq_cnt_q, acq_cnt_d;
  logic [MissW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [TO_LOG2-1:0]  to_cnt_q, to_cnt_d;
  logic                locked_q, locked_d;
  logic                lost_lock_q, lost_lock_d;
  logic                ref_timeout_q, ref_timeout_d;

  logic                ref_rise, fb_rise, win_close, to_hit;
  logic                freq_ok, phase_ok;
  logic [FbW-1:0]      fb_diff;
  logic [3:0]          lock_target, acq_next;
  logic [MissW-1:0]    miss_next;

  // The sign only tells direction of error; the lock decision uses magnitude.
  logic unused_filter_sign;
  assign unused_filter_sign = bus.filter_sign;

  assign ref_rise  = ref_sync_q[1] & ~ref_sync_q[2];
  assign fb_rise   = fb_sync_q[1] & ~fb_sync_q[2];
  assign win_close = ref_rise & (&ref_cnt_q);
  // Fires on the cycle the counter steps into all-ones, not while it is held.
  assign to_hit    = ~ref_rise & (to_cnt_q == ~TO_LOG2'(1));

  // Decision terms: frequency error magnitude, phase threshold, lock target.
  always_comb begin
    fb_diff     = (fb_cnt_q >= WinLen) ? (fb_cnt_q - WinLen) : (WinLen - fb_cnt_q);
    freq_ok     = (fb_diff <= FreqTol);
    phase_ok    = (bus.filter_out <= bus.err_thresh);
    lock_target = (bus.lock_count == 4'd0) ? 4'd1 : bus.lock_count;
    acq_next    = acq_cnt_q + 4'd1;
    miss_next   = miss_cnt_q + MissW'(1);
  end

  // Next-state logic for synchronizers, counters, lock FSM and outputs.
  always_comb begin
    ref_sync_d    = {ref_sync_q[1:0], bus.clk_ref};
    fb_sync_d     = {fb_sync_q[1:0], bus.fb_clk};
    state_d       = state_q;
    ref_cnt_d     = ref_cnt_q;
    fb_cnt_d      = fb_cnt_q;
    acq_cnt_d     = acq_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    to_cnt_d      = to_cnt_q;
    ref_timeout_d = ref_timeout_q;
    lost_lock_d   = 1'b0;

    if (ref_rise) begin
      to_cnt_d      = '0;
      ref_cnt_d     = ref_cnt_q + WIN_LOG2'(1);
      ref_timeout_d = 1'b0;
    end else if (to_cnt_q != '1) begin
      to_cnt_d = to_cnt_q + TO_LOG2'(1);
    end

    // A feedback edge coincident with the close belongs to the new window.
    if (win_close) begin
      fb_cnt_d = fb_rise ? FbW'(1) : '0;
    end else if (fb_rise && (fb_cnt_q != '1)) begin
      fb_cnt_d = fb_cnt_q + FbW'(1);
    end

    if (ref_rise) begin
      case (state_q)
        StUnlocked: begin
          if (win_close && freq_ok) begin
            state_d   = StAcquiring;
            acq_cnt_d = '0;
          end
        end
        StAcquiring: begin
          if ((win_close && !freq_ok) || !phase_ok) begin
            state_d = StUnlocked;
          end else if (acq_next == lock_target) begin
            state_d    = StLocked;
            miss_cnt_d = '0;
          end else begin
            acq_cnt_d = acq_next;
          end
        end
        StLocked: begin
          if (win_close && !freq_ok) begin
            state_d     = StUnlocked;
            lost_lock_d = 1'b1;
          end else if (phase_ok) begin
            miss_cnt_d = '0;
          end else if (miss_next >= MissMax) begin
            state_d     = StUnlocked;
            lost_lock_d = 1'b1;
          end else begin
            miss_cnt_d = miss_next;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end

    if (to_hit) begin
      ref_timeout_d = 1'b1;
      state_d       = StUnlocked;
      lost_lock_d   = (state_q == StLocked);
      ref_cnt_d     = '0;
      fb_cnt_d      = '0;
      acq_cnt_d     = '0;
      miss_cnt_d    = '0;
      to_cnt_d      = '1;
    end

    // Synchronous clear behaves like reset, including silence on lost_lock.
    if (clr) begin
      ref_sync_d    = '0;
      fb_sync_d     = '0;
      state_d       = StUnlocked;
      ref_cnt_d     = '0;
      fb_cnt_d      = '0;
      acq_cnt_d     = '0;
      miss_cnt_d    = '0;
      to_cnt_d      = '0;
      ref_timeout_d = 1'b0;
      lost_lock_d   = 1'b0;
    end

    locked_d = (state_d == StLocked);
  end

  // State register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StUnlocked;
      ref_sync_q    <= '0;
      fb_sync_q     <= '0;
      ref_cnt_q     <= '0;
      fb_cnt_q      <= '0;
      acq_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      to_cnt_q      <= '0;
      locked_q      <= 1'b0;
      lost_lock_q   <= 1'b0;
      ref_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ref_sync_q    <= ref_sync_d;
      fb_sync_q     <= fb_sync_d;
      ref_cnt_q     <= ref_cnt_d;
      fb_cnt_q      <= fb_cnt_d;
      acq_cnt_q     <= acq_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      to_cnt_q      <= to_cnt_d;
      locked_q      <= locked_d;
      lost_lock_q   <= lost_lock_d;
      ref_timeout_q <= ref_timeout_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.lost_lock   = lost_lock_q;
  assign bus.ref_timeout = ref_timeout_q;
  assign bus.lock_state  = state_q;

endmodule

// File: tb/tb_adpll_lock_detect.sv
// Directed bench for adpll_lock_detect. Reference and feedback clocks are
// built from clk by a generator with programmable periods (in clk cycles)
// and start delays; expectations are tied to the n-th generated ref edge.
module tb_adpll_lock_detect;

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  adpll_lock_detect_if bus ();

  adpll_lock_detect #(
    .WIN_LOG2(4),
    .FREQ_TOL(1),
    .MISS_MAX(3),
    .TO_LOG2 (10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Generator controls, written by the test tasks at posedge.
  bit gen_run  = 1'b0;
  bit ref_hold = 1'b0;
  int ref_per  = 8;
  int fb_per   = 8;
  int ref_dly  = 0;
  int fb_dly   = 0;

  // Generator-private state.
  int gen_cyc   = 0;
  int ref_ph    = 0;
  int fb_ph     = 0;
  int ref_edges = 0;

  // Monitor totals.
  int lost_total = 0;
  int nz_total   = 0;

  // Clock generator: drives clk_ref / fb_clk on falling clk edges.
  always @(negedge clk) begin
    if (!gen_run) begin
      gen_cyc     = 0;
      ref_ph      = 0;
      fb_ph       = 0;
      ref_edges   = 0;
      bus.clk_ref = 1'b0;
      bus.fb_clk  = 1'b0;
    end else begin
      if (ref_hold || gen_cyc < ref_dly) begin
        bus.clk_ref = 1'b0;
        ref_ph      = 0;
      end else begin
        if (ref_ph == 0) ref_edges++;
        bus.clk_ref = (ref_ph < ref_per / 2);
        ref_ph      = (ref_ph == ref_per - 1) ? 0 : ref_ph + 1;
      end
      if (gen_cyc < fb_dly) begin
        bus.fb_clk = 1'b0;
        fb_ph      = 0;
      end else begin
        bus.fb_clk = (fb_ph < fb_per / 2);
        fb_ph      = (fb_ph == fb_per - 1) ? 0 : fb_ph + 1;
      end
      gen_cyc++;
    end
  end

  // Pulse and state monitor.
  always @(negedge clk) begin
    if (bus.lost_lock === 1'b1) lost_total++;
    if (bus.lock_state !== 2'd0) nz_total++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_edges(input int n, input string what);
    int budget;
    budget = 3000;
    while (ref_edges < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (ref_edges < n) begin
      checks++;
      errors++;
      $display("FAIL %s: ref edge count %0d, required %0d", what, ref_edges, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    gen_run  = 1'b0;
    ref_hold = 1'b0;
    clr      = 1'b0;
    rst_n    = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic start_gen(input int rp, input int fp, input int rd, input int fd);
    @(posedge clk);
    ref_per = rp;
    fb_per  = fp;
    ref_dly = rd;
    fb_dly  = fd;
    gen_run = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clr   = 1'b0;
    start_gen(8, 6, 0, 0);
    cycles(20);
    checks++;
    if (bus.locked !== 1'b0) begin
      errors++; $display("FAIL reset_locked: got %b want 0", bus.locked);
    end
    checks++;
    if (bus.lost_lock !== 1'b0) begin
      errors++; $display("FAIL reset_lost_lock: got %b want 0", bus.lost_lock);
    end
    checks++;
    if (bus.ref_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_ref_timeout: got %b want 0", bus.ref_timeout);
    end
    checks++;
    if (bus.lock_state !== 2'd0) begin
      errors++; $display("FAIL reset_lock_state: got %0d want 0", bus.lock_state);
    end
    rst_n = 1'b1;
    cycles(10);
    checks++;
    if (bus.lock_state !== 2'd0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: state %0d locked %b want 0/0", bus.lock_state, bus.locked);
    end
  endtask

  task automatic test_clean_lock();
    int base;
    do_reset();
    base = lost_total;
    bus.filter_out  = 5'd2;
    bus.err_thresh  = 5'd4;
    bus.lock_count  = 4'd5;
    bus.filter_sign = 1'b1;
    start_gen(8, 8, 0, 0);
    wait_edges(16, "clean_w16");
    checks++;
    if (bus.lock_state !== 2'd0) begin
      errors++; $display("FAIL clean_pre_close: state %0d want 0", bus.lock_state);
    end
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      errors++; $display("FAIL clean_acquiring: state %0d want 1", bus.lock_state);
    end
    wait_edges(20, "clean_w20");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd1 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL clean_edge20: state %0d locked %b want 1/0", bus.lock_state, bus.locked);
    end
    wait_edges(21, "clean_w21");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2 || bus.locked !== 1'b1) begin
      errors++;
      $display("FAIL clean_locked: state %0d locked %b want 2/1", bus.lock_state, bus.locked);
    end
    checks++;
    if (lost_total - base !== 0) begin
      errors++; $display("FAIL clean_no_lost: pulses %0d want 0", lost_total - base);
    end
  endtask

  task automatic test_phase_loss();
    int base;
    base = lost_total;
    wait_edges(22, "phase_w22");
    bus.filter_out = 5'd9;
    wait_edges(24, "phase_w24");
    bus.filter_out = 5'd2;
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      errors++; $display("FAIL phase_two_miss: state %0d want 2", bus.lock_state);
    end
    wait_edges(25, "phase_w25");
    bus.filter_out = 5'd9;
    wait_edges(26, "phase_w26");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      errors++; $display("FAIL phase_second_miss: state %0d want 2", bus.lock_state);
    end
    wait_edges(27, "phase_w27");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL phase_drop: state %0d locked %b want 0/0", bus.lock_state, bus.locked);
    end
    bus.filter_out = 5'd2;
    cycles(20);
    checks++;
    if (lost_total - base !== 1) begin
      errors++; $display("FAIL phase_lost_pulse: pulses %0d want 1", lost_total - base);
    end
  endtask

  task automatic test_timeout();
    int base;
    int e;
    wait_edges(37, "timeout_relock");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      errors++; $display("FAIL timeout_relocked: state %0d want 2", bus.lock_state);
    end
    base = lost_total;
    @(posedge clk);
    ref_hold = 1'b1;
    cycles(1000);
    checks++;
    if (bus.ref_timeout !== 1'b0 || bus.lock_state !== 2'd2) begin
      errors++;
      $display("FAIL timeout_early: to %b state %0d want 0/2", bus.ref_timeout, bus.lock_state);
    end
    cycles(100);
    checks++;
    if (bus.ref_timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_flag: got %b want 1", bus.ref_timeout);
    end
    checks++;
    if (bus.locked !== 1'b0 || bus.lock_state !== 2'd0) begin
      errors++;
      $display("FAIL timeout_unlock: locked %b state %0d want 0/0", bus.locked, bus.lock_state);
    end
    checks++;
    if (lost_total - base !== 1) begin
      errors++; $display("FAIL timeout_lost_pulse: pulses %0d want 1", lost_total - base);
    end
    e = ref_edges;
    @(posedge clk);
    ref_hold = 1'b0;
    wait_edges(e + 1, "timeout_resume");
    cycles(3);
    checks++;
    if (bus.ref_timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: got %b want 0", bus.ref_timeout);
    end
  endtask

  task automatic test_freq_error();
    int nz_base;
    // 18 fb edges per 16-edge window (first window 19): never acquires.
    do_reset();
    nz_base = nz_total;
    start_gen(9, 8, 16, 0);
    wait_edges(48, "freq18_w48");
    cycles(3);
    checks++;
    if (nz_total - nz_base !== 0) begin
      errors++; $display("FAIL freq18_stay: cycles out of UNLOCKED %0d want 0", nz_total - nz_base);
    end
    checks++;
    if (bus.lock_state !== 2'd0) begin
      errors++; $display("FAIL freq18_state: state %0d want 0", bus.lock_state);
    end
    // 16 then 17 fb edges per window: within tolerance.
    do_reset();
    start_gen(17, 16, 0, 0);
    wait_edges(16, "freq17_w16");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      errors++; $display("FAIL freq17_acquiring: state %0d want 1", bus.lock_state);
    end
    wait_edges(21, "freq17_w21");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      errors++; $display("FAIL freq17_locked: state %0d want 2", bus.lock_state);
    end
    wait_edges(32, "freq17_w32");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd2) begin
      errors++; $display("FAIL freq17_hold: state %0d want 2", bus.lock_state);
    end
  endtask

  task automatic test_simultaneous();
    int base;
    // fb starts one ref period late: window 1 sees 14 fb edges before the
    // close plus one coincident with it, so it must fail.
    do_reset();
    start_gen(8, 8, 0, 8);
    wait_edges(16, "simul_w16");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd0) begin
      errors++; $display("FAIL simul_first_window: state %0d want 0", bus.lock_state);
    end
    wait_edges(32, "simul_w32");
    cycles(3);
    checks++;
    if (bus.lock_state !== 2'd1) begin
      errors++; $display("FAIL simul_second_window: state %0d want 1", bus.lock_state);
    end
    wait_edges(34, "simul_w34");
    cycles(3);
    base = lost_total;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++;
    if (bus.lock_state !== 2'd0 || bus.locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_unlock: state %0d locked %b want 0/0", bus.lock_state, bus.locked);
    end
    cycles(5);
    checks++;
    if (lost_total - base !== 0) begin
      errors++; $display("FAIL clr_no_lost: pulses %0d want 0", lost_total - base);
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    clr             = 1'b0;
    bus.filter_sign = 1'b0;
    bus.filter_out  = 5'd2;
    bus.err_thresh  = 5'd4;
    bus.lock_count  = 4'd5;
    test_reset();
    test_clean_lock();
    test_phase_loss();
    test_timeout();
    bus.filter_sign = 1'b0;
    test_freq_error();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detect.md
# adpll_lock_detect

Lock detector downstream of the ADPLL core. It consumes the reference clock, the feedback clock and the signed loop-filter output. Frequency lock is judged by counting feedback edges over a window of reference edges; phase lock is judged by the filter magnitude sampled on each reference edge. The result is a qualified `locked` flag plus loss-of-lock and reference-timeout indications, for status readout and for gating downstream CDR logic.

## Interface
- WIN_LOG2, 4: frequency window length is 2^WIN_LOG2 reference rising edges.
- FREQ_TOL, 1: allowed |fb edges − 2^WIN_LOG2| per window.
- MISS_MAX, 3: consecutive phase failures tolerated in LOCKED before dropping lock.
- TO_LOG2, 10: reference timeout is 2^TO_LOG2 clk cycles with no reference edge.

Ports:
- clk  in  1  system clock; all logic synchronous to its rising edge.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- clr  in  1  synchronous clear; same effect as reset, applied at the next clk edge.
- clk_ref  in  1  reference clock, asynchronous to clk.
- fb_clk  in  1  feedback clock from the divider mux, asynchronous to clk.
- filter_sign  in  1  loop filter sign, synchronous to clk; ignored by the phase check.
- filter_out  in  5  loop filter magnitude, synchronous to clk.
- err_thresh  in  5  phase-OK threshold; the check passes when filter_out <= err_thresh.
- lock_count  in  4  consecutive phase-OK reference edges required to lock; 0 is treated as 1.
- locked  out  1  high in LOCKED state.
- lost_lock  out  1  one-cycle pulse on any LOCKED→UNLOCKED transition.
- ref_timeout  out  1  sticky flag, set on reference timeout, cleared by reset, clr, or the next reference edge.
- lock_state  out  2  state: 0 UNLOCKED, 1 ACQUIRING, 2 LOCKED.

## Operation
- **Synchronizers.** clk_ref and fb_clk each go through a 3-flop shift register s[0..2].
  - Rise pulses: ref_rise = s_ref[1] & ~s_ref[2]; fb_rise likewise.
  - All decisions below are made at clk edges where the corresponding pulse is high.
- **Window counters.**
  - ref_cnt (WIN_LOG2 bits) increments on ref_rise.
  - fb_cnt (WIN_LOG2+2 bits) increments on fb_rise and saturates at all-ones.
  - The window closes on the ref_rise where ref_cnt wraps from all-ones to 0. freq_ok = |fb_cnt − 2^WIN_LOG2| <= FREQ_TOL, evaluated as an unsigned difference with no wrap.
  - On close, fb_cnt loads 1 if fb_rise is high in the same cycle, else 0.
  - An fb_rise in the closing cycle counts toward the new window only; the closing comparison uses the pre-increment fb_cnt.
- **Phase check.** On each ref_rise, phase_ok = (filter_out <= err_thresh), using the filter_out value present in that cycle.
- **State machine** (evaluated on ref_rise unless noted):
  - UNLOCKED: on window close with freq_ok → ACQUIRING, with acq_cnt = 0.
  - ACQUIRING:
    - If phase_ok: acq_cnt += 1. When acq_cnt reaches max(lock_count,1) → LOCKED with miss_cnt = 0.
    - If not phase_ok → UNLOCKED.
    - On window close with !freq_ok → UNLOCKED.
    - When window close and phase fail happen in the same cycle, the result is UNLOCKED.
    - The entering ref_rise itself does not count toward acq_cnt.
  - LOCKED:
    - phase_ok clears miss_cnt. A phase failure increments miss_cnt; reaching MISS_MAX → UNLOCKED.
    - Window close with !freq_ok → UNLOCKED immediately, regardless of miss_cnt.
    - Every exit from LOCKED pulses lost_lock.
- **Timeout.**
  - to_cnt (TO_LOG2 bits) counts clk cycles and clears on ref_rise.
  - On reaching all-ones: set ref_timeout, force UNLOCKED (lost_lock pulse if previously LOCKED), clear ref_cnt, fb_cnt, acq_cnt and miss_cnt, and hold to_cnt at all-ones.
- **Reset/clr mid-operation.** All state returns to reset values with no lost_lock pulse. The synchronizers are cleared as well, so an input already high is not seen as a rise.

## Timing
- Reset values: locked=0, lost_lock=0, ref_timeout=0, lock_state=0. All counters and synchronizer flops are 0.
- Latency from a clk_ref rising transition (settled before clk edge k) to the ref_rise decision is the clk edge k+2. State and outputs update at that edge.
- All outputs are registered. locked and lock_state change at the same edge; the lost_lock pulse is high for exactly the cycle after that edge.
- Input clocks must have high and low phases of at least 2 clk periods; faster inputs are outside specification (edges may be missed).

## Test plan
- **Reset.** Hold rst_n=0 with both clocks toggling. Required: all outputs 0. Release; no edge is detected before 2 clk cycles.
- **Clean lock.** clk_ref = fb_clk = clk/8, filter_out=2, err_thresh=4, lock_count=5. Required: ACQUIRING after the first window close (16th ref edge), LOCKED after 5 further ref edges.
- **Frequency error.** fb_clk 18 edges per 16 ref edges with FREQ_TOL=1. Required: stays UNLOCKED. With 17 edges: proceeds to ACQUIRING.
- **Phase loss.** In LOCKED, drive filter_out=9 (err_thresh=4) for 2 ref edges, then 2. Required: stays locked. Drive 9 for 3 consecutive edges. Required: UNLOCKED with a single lost_lock pulse.
- **Timeout.** In LOCKED, stop clk_ref for 1024 clk cycles. Required: ref_timeout=1, locked=0, one lost_lock pulse. The next ref edge clears ref_timeout.
- **Simultaneous edges.** ref_rise and fb_rise in the same cycle as window close. Required: the fb edge counts toward the new window. Assert clr mid-ACQUIRING. Required: UNLOCKED with no lost_lock pulse.
